param_updown_counter: RTL
=========================

Name: param_updown_counter

Overview:
Parametrised synchronous up/down counter. It is the generalised successor to the fixed 3-bit down counter and the team's standard counter primitive for timers, dividers and sequencers. It adds a configurable width and modulus, a direction select, a count enable and a synchronous parallel load. It also adds a wrap-or-saturate mode, a terminal-count flag and a registered wrap pulse.

Parameters:
WIDTH, 3, counter width in bits (1..32)
MODULUS, 8, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
RST_VAL, 0, value of q after reset; must be < MODULUS
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous parallel load
d  input  WIDTH  load value
q  output  WIDTH  registered count
tc  output  1  terminal count, combinational from q and up
wrap  output  1  registered one-cycle pulse on wrap or saturate-hit

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). No asynchronous paths.
- Priority at each rising edge: rst > load > en > hold.
- Reset:
  - rst=1 at an edge: q <= RST_VAL, wrap <= 0.
  - load and en are ignored in that cycle.
  - Reset is honoured mid-count and mid-load with no residue.
- Load:
  - load=1: q <= min(d, MODULUS-1). Out-of-range d clamps to MODULUS-1.
  - wrap <= 0. en and up are ignored.
- Count, en=1 and load=0:
  - up=1, q < MODULUS-1: q <= q+1.
  - up=1, q = MODULUS-1: SATURATE=0 gives q <= 0; SATURATE=1 holds q.
  - up=0, q > 0: q <= q-1.
  - up=0, q = 0: SATURATE=0 gives q <= MODULUS-1; SATURATE=1 holds q.
- Hold: en=0 and load=0 gives q unchanged and wrap <= 0.
- tc (combinational):
  - tc = (up & q==MODULUS-1) | (~up & q==0).
  - Independent of en. Flipping up changes tc in the same cycle.
- wrap (registered):
  - wrap <= 1 only on an edge where en=1, load=0, rst=0 and tc=1. This covers both the wrap and the saturate-hold cases.
  - Otherwise wrap <= 0. It is high for exactly one cycle per event.
  - Continuous saturation with en held high gives wrap=1 every cycle.
- Latency:
  - q reflects load, count or reset one cycle after the sampling edge.
  - wrap coincides with the new q.
- Arithmetic:
  - Next-state computation uses WIDTH+1 bits internally to avoid overflow when MODULUS = 2**WIDTH.
  - q never holds a value >= MODULUS.
- Direction change: up may change on any cycle and takes effect at the next edge. No dead cycle.
- Elaboration:
  - Out-of-range parameters (MODULUS > 2**WIDTH, MODULUS < 2, RST_VAL >= MODULUS) must produce an elaboration error. Use a generate-time check.

Test Plan:
1. Defaults (WIDTH=3, MODULUS=8). rst=1 for 2 edges, then en=1, up=0. Expected q: 0 -> 7 -> 6 … -> 0 -> 7. wrap=1 on the cycle q first shows 7. tc=1 whenever q=0.
2. MODULUS=10, WIDTH=4, up=1, en=1 from reset 0. Expected q: 0..9 -> 0. tc=1 at q=9. wrap pulses once per 10 cycles; q is never 10-15.
3. SATURATE=1, up=1, en=1. Expected: q reaches 7 and holds; wrap stays 1 each cycle while held. Switch up=0: q goes 6 next edge, wrap=0.
4. Load priority: with MODULUS=10, assert load=1, d=4'd13, en=1 → q=9 next cycle, wrap=0. Then load=1, d=3 with rst=1 → q=RST_VAL, load ignored.
5. Enable and direction: en toggled 1/0 every cycle from q=5, up=1. Expected q: 5,6,6,7,7,0. Flip up mid-run: q=3, up=0 gives next q=2. tc tracks the up change combinationally.
6. Reset mid-operation: counting down from q=2 with en=1, assert rst for 1 cycle → q=RST_VAL, wrap=0. Counting resumes correctly on the following edge.

Source files
------------

// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter with enable, parallel load,
// a choice of wrap or saturate at the range ends, a terminal-count flag and a registered wrap pulse.
module param_updown_counter #(
  parameter int unsigned     WIDTH    = 3,
  parameter longint unsigned MODULUS  = 8,
  parameter longint unsigned RST_VAL  = 0,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // Reject parameter sets that could let q leave 0..MODULUS-1.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("param_updown_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (RST_VAL >= MODULUS) begin : g_bad_rst_val
    $error("param_updown_counter: RST_VAL must be below MODULUS");
  end

  localparam longint unsigned  MaxL   = MODULUS - 1;
  localparam logic [WIDTH:0]   MaxVal = MaxL[WIDTH:0];
  localparam logic [WIDTH-1:0] RstVal = RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   qExt, dExt, nextExt;

  // The extra top bit keeps MODULUS == 2**WIDTH from overflowing.
  assign qExt = {1'b0, count_q};
  assign dExt = {1'b0, d};

  assign tc = up ? (qExt == MaxVal) : (count_q == '0);

  always_comb begin
    nextExt = qExt;
    wrap_d  = 1'b0;
    if (load) begin
      nextExt = (dExt > MaxVal) ? MaxVal : dExt;
    end else if (en) begin
      wrap_d = tc;
      if (up) begin
        nextExt = tc ? (SATURATE ? qExt : '0) : (qExt + 1'b1);
      end else begin
        nextExt = tc ? (SATURATE ? qExt : MaxVal) : (qExt - 1'b1);
      end
    end
    // Final clamp guarantees q never reaches MODULUS whatever the path above.
    count_d = (nextExt > MaxVal) ? MaxVal[WIDTH-1:0] : nextExt[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RstVal;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = count_q;
  assign wrap = wrap_q;

endmodule
